fadd_issue_ctrl: RTL and testbench



---
 rtl/fadd_issue_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_fadd_issue_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_issue_ctrl.sv
// Issue/retire controller for the pipelined FP adder: buffers requests,
// caps in-flight ops and re-pairs each in-order result with its request tag.
module fadd_issue_ctrl #(
    parameter int EXPWIDTH        = 5,
    parameter int PRECISION       = 3,
    parameter int CTRL_C_WIDTH    = 16,
    parameter int DEPTH_WARP      = 4,
    parameter int REQ_DEPTH       = 4,
    parameter int MAX_OUTSTANDING = 4,
    localparam int DW = EXPWIDTH + PRECISION + 1,
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [DW-1:0]           req_a_i,
    input  logic [DW-1:0]           req_b_i,
    input  logic [2:0]              req_rm_i,
    input  logic [CTRL_C_WIDTH-1:0] req_c_i,
    input  logic [7:0]              req_reg_idxw_i,
    input  logic [DEPTH_WARP-1:0]   req_warpid_i,

    output logic                    fa_valid_o,
    input  logic                    fa_ready_i,
    output logic [DW-1:0]           fa_a_o,
    output logic [DW-1:0]           fa_b_o,
    output logic [2:0]              fa_rm_o,

    input  logic                    fr_valid_i,
    output logic                    fr_ready_o,
    input  logic [DW-1:0]           fr_result_i,
    input  logic [4:0]              fr_fflags_i,

    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DW-1:0]           rsp_result_o,
    output logic [4:0]              rsp_fflags_o,
    output logic [CTRL_C_WIDTH-1:0] rsp_c_o,
    output logic [2:0]              rsp_rm_o,
    output logic [7:0]              rsp_reg_idxw_o,
    output logic [DEPTH_WARP-1:0]   rsp_warpid_o,

    output logic [OW-1:0]           outstanding_o,
    output logic                    err_o
);

    localparam int RAW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int TAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef struct packed {
        logic [DW-1:0]           a;
        logic [DW-1:0]           b;
        logic [2:0]              rm;
        logic [CTRL_C_WIDTH-1:0] c;
        logic [7:0]              reg_idxw;
        logic [DEPTH_WARP-1:0]   warpid;
    } req_t;

    typedef struct packed {
        logic [CTRL_C_WIDTH-1:0] c;
        logic [2:0]              rm;
        logic [7:0]              reg_idxw;
        logic [DEPTH_WARP-1:0]   warpid;
    } tag_t;

    req_t             req_mem [REQ_DEPTH];
    logic [RAW-1:0]   req_wp;
    logic [RAW-1:0]   req_rp;
    logic [RAW:0]     req_cnt;
    logic             req_full;
    logic             req_empty;
    logic             req_push;
    req_t             req_in;
    req_t             req_head;

    tag_t             tag_mem [MAX_OUTSTANDING];
    logic [TAW-1:0]   tag_wp;
    logic [TAW-1:0]   tag_rp;
    logic [OW-1:0]    tag_cnt;
    logic             tag_empty;
    tag_t             tag_in;
    tag_t             tag_head;

    logic             issue;
    logic             retire;
    logic             retire_ok;
    logic             retire_err;

    assign req_full    = (req_cnt == (RAW+1)'(REQ_DEPTH));
    assign req_empty   = (req_cnt == '0);
    assign req_ready_o = !rst && !req_full;
    assign req_push    = req_valid_i && req_ready_o;

    assign req_in = '{
        a:        req_a_i,
        b:        req_b_i,
        rm:       req_rm_i,
        c:        req_c_i,
        reg_idxw: req_reg_idxw_i,
        warpid:   req_warpid_i
    };
    assign req_head = req_mem[req_rp];

    assign fa_valid_o = !req_empty
                     && (tag_cnt < OW'(MAX_OUTSTANDING));
    assign fa_a_o     = req_head.a;
    assign fa_b_o     = req_head.b;
    assign fa_rm_o    = req_head.rm;
    assign issue      = fa_valid_o && fa_ready_i;

    assign tag_in = '{
        c:        req_head.c,
        rm:       req_head.rm,
        reg_idxw: req_head.reg_idxw,
        warpid:   req_head.warpid
    };
    assign tag_head  = tag_mem[tag_rp];
    assign tag_empty = (tag_cnt == '0);

    assign fr_ready_o = !rsp_valid_o || rsp_ready_i;
    assign retire     = fr_valid_i && fr_ready_o;
    assign retire_ok  = retire && !tag_empty;
    assign retire_err = retire && tag_empty;

    assign outstanding_o = tag_cnt;

    always_ff @(posedge clk) begin
        if (req_push) begin
            req_mem[req_wp] <= req_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_wp  <= '0;
            req_rp  <= '0;
            req_cnt <= '0;
        end else begin
            if (req_push) begin
                req_wp <= req_wp + RAW'(1);
            end
            if (issue) begin
                req_rp <= req_rp + RAW'(1);
            end
            unique case ({req_push, issue})
                2'b10:   req_cnt <= req_cnt + (RAW+1)'(1);
                2'b01:   req_cnt <= req_cnt - (RAW+1)'(1);
                default: req_cnt <= req_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[tag_wp] <= tag_in;
        end
    end

    // Issue is capped at MAX_OUTSTANDING, so the tag FIFO cannot overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wp  <= '0;
            tag_rp  <= '0;
            tag_cnt <= '0;
        end else begin
            if (issue) begin
                tag_wp <= tag_wp + TAW'(1);
            end
            if (retire_ok) begin
                tag_rp <= tag_rp + TAW'(1);
            end
            unique case ({issue, retire_ok})
                2'b10:   tag_cnt <= tag_cnt + OW'(1);
                2'b01:   tag_cnt <= tag_cnt - OW'(1);
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_o    <= 1'b0;
            rsp_result_o   <= '0;
            rsp_fflags_o   <= '0;
            rsp_c_o        <= '0;
            rsp_rm_o       <= '0;
            rsp_reg_idxw_o <= '0;
            rsp_warpid_o   <= '0;
            err_o          <= 1'b0;
        end else begin
            if (retire_ok) begin
                rsp_valid_o    <= 1'b1;
                rsp_result_o   <= fr_result_i;
                rsp_fflags_o   <= fr_fflags_i;
                rsp_c_o        <= tag_head.c;
                rsp_rm_o       <= tag_head.rm;
                rsp_reg_idxw_o <= tag_head.reg_idxw;
                rsp_warpid_o   <= tag_head.warpid;
            end else if (rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
            end
            // A result with no matching tag is dropped and flagged.
            if (retire_err) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fadd_issue_ctrl.sv
// Directed bench for fadd_issue_ctrl; the bench plays scheduler, adder and
// writeback, with a scoreboard queue checked by a response monitor.
module tb_fadd_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [8:0]  req_a_i, req_b_i;
    logic [2:0]  req_rm_i;
    logic [15:0] req_c_i;
    logic [7:0]  req_reg_idxw_i;
    logic [3:0]  req_warpid_i;
    logic        fa_valid_o, fa_ready_i;
    logic [8:0]  fa_a_o, fa_b_o;
    logic [2:0]  fa_rm_o;
    logic        fr_valid_i, fr_ready_o;
    logic [8:0]  fr_result_i;
    logic [4:0]  fr_fflags_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [8:0]  rsp_result_o;
    logic [4:0]  rsp_fflags_o;
    logic [15:0] rsp_c_o;
    logic [2:0]  rsp_rm_o;
    logic [7:0]  rsp_reg_idxw_o;
    logic [3:0]  rsp_warpid_o;
    logic [2:0]  outstanding_o;
    logic        err_o;

    always #5 clk = ~clk;

    fadd_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rm_i(req_rm_i),
        .req_c_i(req_c_i), .req_reg_idxw_i(req_reg_idxw_i),
        .req_warpid_i(req_warpid_i),
        .fa_valid_o(fa_valid_o), .fa_ready_i(fa_ready_i),
        .fa_a_o(fa_a_o), .fa_b_o(fa_b_o), .fa_rm_o(fa_rm_o),
        .fr_valid_i(fr_valid_i), .fr_ready_o(fr_ready_o),
        .fr_result_i(fr_result_i), .fr_fflags_i(fr_fflags_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_fflags_o(rsp_fflags_o),
        .rsp_c_o(rsp_c_o), .rsp_rm_o(rsp_rm_o),
        .rsp_reg_idxw_o(rsp_reg_idxw_o), .rsp_warpid_o(rsp_warpid_o),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    typedef struct packed {
        logic [8:0]  res;
        logic [4:0]  ff;
        logic [15:0] c;
        logic [2:0]  rm;
        logic [7:0]  ri;
        logic [3:0]  w;
    } exp_t;

    exp_t expq[$];
    int   tests = 0;
    int   fails = 0;
    int   issue_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic fail(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: got timeout/unexpected, expected event", nm);
    endtask

    // Response monitor: every writeback handshake pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid_o && rsp_ready_i) begin
            if (expq.size() == 0) begin
                fail("rsp_unexpected");
            end else begin
                e = expq.pop_front();
                chk("rsp_result", rsp_result_o, e.res);
                chk("rsp_fflags", rsp_fflags_o, e.ff);
                chk("rsp_c", rsp_c_o, e.c);
                chk("rsp_rm", rsp_rm_o, e.rm);
                chk("rsp_reg", rsp_reg_idxw_o, e.ri);
                chk("rsp_warp", rsp_warpid_o, e.w);
            end
        end
        if (!rst && fa_valid_o && fa_ready_i) issue_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [8:0] a, input logic [8:0] b,
                            input logic [2:0] rm, input logic [15:0] c,
                            input logic [7:0] ri, input logic [3:0] w);
        int k = 0;
        req_valid_i = 1'b1;
        req_a_i = a; req_b_i = b; req_rm_i = rm;
        req_c_i = c; req_reg_idxw_i = ri; req_warpid_i = w;
        @(negedge clk);
        while (!req_ready_o && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready_o) fail("req_timeout");
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic ret(input logic [8:0] res, input logic [4:0] ff,
                       input logic [15:0] c, input logic [2:0] rm,
                       input logic [7:0] ri, input logic [3:0] w);
        int k = 0;
        fr_valid_i = 1'b1;
        fr_result_i = res;
        fr_fflags_i = ff;
        @(negedge clk);
        while (!fr_ready_o && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!fr_ready_o) fail("ret_timeout");
        expq.push_back('{res: res, ff: ff, c: c, rm: rm, ri: ri, w: w});
        tick();
        fr_valid_i = 1'b0;
    endtask

    task automatic wait_outs(input logic [2:0] n);
        int k = 0;
        @(negedge clk);
        while (outstanding_o != n && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("outstanding_wait", outstanding_o, n);
        tick();
    endtask

    initial begin
        int base;
        logic [8:0]  hold_res;
        logic [15:0] hold_c;

        rst = 1'b1;
        req_valid_i = 0; req_a_i = 0; req_b_i = 0; req_rm_i = 0;
        req_c_i = 0; req_reg_idxw_i = 0; req_warpid_i = 0;
        fa_ready_i = 0; fr_valid_i = 0; fr_result_i = 0; fr_fflags_i = 0;
        rsp_ready_i = 1;
        repeat (3) @(posedge clk);
        #1;

        @(negedge clk);
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_fa_valid", fa_valid_o, 0);
        chk("rst_fr_ready", fr_ready_o, 1);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_result", rsp_result_o, 0);
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_err", err_o, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready_o, 1);
        tick();

        // Single op
        fa_ready_i = 1'b1;
        req_valid_i = 1'b1;
        req_a_i = 9'h0A0; req_b_i = 9'h0A0; req_rm_i = 3'd0;
        req_c_i = 16'h1234; req_reg_idxw_i = 8'h11; req_warpid_i = 4'd3;
        @(negedge clk);
        chk("single_fa_valid_t", fa_valid_o, 0);
        tick();
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("single_fa_valid_t1", fa_valid_o, 1);
        chk("single_fa_a", fa_a_o, 9'h0A0);
        chk("single_fa_b", fa_b_o, 9'h0A0);
        tick();
        @(negedge clk);
        chk("single_outs_1", outstanding_o, 1);
        tick();
        ret(9'h0A8, 5'h00, 16'h1234, 3'd0, 8'h11, 4'd3);
        @(negedge clk);
        chk("single_rsp_valid", rsp_valid_o, 1);
        chk("single_outs_0", outstanding_o, 0);
        tick();

        // Outstanding cap
        base = issue_cnt;
        for (int i = 0; i < 6; i++)
            send_req(9'h040 + 9'(i), 9'h041, 3'(i), 16'h0100 + 16'(i),
                     8'h20 + 8'(i), 4'(i));
        repeat (3) tick();
        @(negedge clk);
        chk("cap_issued_4", issue_cnt - base, 4);
        chk("cap_outs_4", outstanding_o, 4);
        chk("cap_fa_valid_0", fa_valid_o, 0);
        tick();
        ret(9'h050, 5'h01, 16'h0100, 3'd0, 8'h20, 4'd0);
        @(negedge clk);
        chk("cap_outs_3", outstanding_o, 3);
        chk("cap_fa_valid_1", fa_valid_o, 1);
        tick();
        @(negedge clk);
        chk("cap_issued_5", issue_cnt - base, 5);
        chk("cap_outs_refill", outstanding_o, 4);
        tick();
        for (int i = 1; i < 6; i++)
            ret(9'h050 + 9'(i), 5'(i), 16'h0100 + 16'(i), 3'(i),
                8'h20 + 8'(i), 4'(i));
        wait_outs(3'd0);

        // Tag order
        for (int i = 1; i <= 4; i++)
            send_req(9'h060 + 9'(i), 9'h061, 3'd1, 16'(i),
                     8'h30 + 8'(i), 4'(i));
        wait_outs(3'd4);
        for (int i = 1; i <= 4; i++)
            ret(9'h070 + 9'(i), 5'h00, 16'(i), 3'd1, 8'h30 + 8'(i), 4'(i));
        wait_outs(3'd0);

        // Back-pressure
        send_req(9'h081, 9'h082, 3'd2, 16'h0005, 8'h45, 4'd5);
        send_req(9'h083, 9'h084, 3'd2, 16'h0006, 8'h46, 4'd6);
        wait_outs(3'd2);
        rsp_ready_i = 1'b0;
        ret(9'h0C5, 5'h02, 16'h0005, 3'd2, 8'h45, 4'd5);
        fr_valid_i = 1'b1;
        fr_result_i = 9'h0C6;
        fr_fflags_i = 5'h04;
        @(negedge clk);
        chk("bp_fr_ready_0", fr_ready_o, 0);
        chk("bp_rsp_valid", rsp_valid_o, 1);
        hold_res = rsp_result_o;
        hold_c = rsp_c_o;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("bp_fr_ready_hold", fr_ready_o, 0);
            chk("bp_result_stable", rsp_result_o, hold_res);
            chk("bp_c_stable", rsp_c_o, hold_c);
        end
        tick();
        rsp_ready_i = 1'b1;
        expq.push_back('{res: 9'h0C6, ff: 5'h04, c: 16'h0006, rm: 3'd2,
                         ri: 8'h46, w: 4'd6});
        @(negedge clk);
        chk("bp_fr_ready_1", fr_ready_o, 1);
        tick();
        fr_valid_i = 1'b0;
        @(negedge clk);
        chk("bp_drain2_valid", rsp_valid_o, 1);
        chk("bp_drain2_c", rsp_c_o, 16'h0006);
        tick();
        wait_outs(3'd0);

        // Request FIFO full
        fa_ready_i = 1'b0;
        for (int i = 0; i < 4; i++)
            send_req(9'h090 + 9'(i), 9'h091, 3'd3, 16'h0A00 + 16'(i),
                     8'h50 + 8'(i), 4'(i));
        req_valid_i = 1'b1;
        req_a_i = 9'h094; req_b_i = 9'h091; req_rm_i = 3'd3;
        req_c_i = 16'h0A04; req_reg_idxw_i = 8'h54; req_warpid_i = 4'd4;
        @(negedge clk);
        chk("full_ready_0", req_ready_o, 0);
        tick();
        @(negedge clk);
        chk("full_ready_hold", req_ready_o, 0);
        tick();
        fa_ready_i = 1'b1;
        @(negedge clk);
        chk("full_no_admit_on_pop", req_ready_o, 0);
        chk("full_fa_valid", fa_valid_o, 1);
        tick();
        @(negedge clk);
        chk("full_ready_after_issue", req_ready_o, 1);
        tick();
        req_valid_i = 1'b0;
        wait_outs(3'd4);
        for (int i = 0; i < 5; i++)
            ret(9'h0B0 + 9'(i), 5'h00, 16'h0A00 + 16'(i), 3'd3,
                8'h50 + 8'(i), 4'(i));
        wait_outs(3'd0);

        // Spurious result
        fr_valid_i = 1'b1;
        fr_result_i = 9'h1FF;
        fr_fflags_i = 5'h1F;
        @(negedge clk);
        chk("spur_fr_ready", fr_ready_o, 1);
        tick();
        fr_valid_i = 1'b0;
        @(negedge clk);
        chk("spur_err", err_o, 1);
        chk("spur_rsp_valid", rsp_valid_o, 0);
        chk("spur_rsp_c_kept", rsp_c_o, 16'h0A04);
        chk("spur_outs", outstanding_o, 0);
        tick();

        // Reset with ops in flight
        for (int i = 0; i < 3; i++)
            send_req(9'h0D0 + 9'(i), 9'h0D1, 3'd4, 16'h0C00 + 16'(i),
                     8'h60 + 8'(i), 4'(i));
        wait_outs(3'd3);
        fa_ready_i = 1'b0;
        send_req(9'h0D3, 9'h0D1, 3'd4, 16'h0C03, 8'h63, 4'd3);
        rst = 1'b1;
        fa_ready_i = 1'b1;
        @(negedge clk);
        chk("midrst_req_ready", req_ready_o, 0);
        tick();
        @(negedge clk);
        chk("midrst_outs", outstanding_o, 0);
        chk("midrst_fa_valid", fa_valid_o, 0);
        chk("midrst_err", err_o, 0);
        chk("midrst_rsp_valid", rsp_valid_o, 0);
        chk("midrst_rsp_result", rsp_result_o, 0);
        chk("midrst_rsp_c", rsp_c_o, 0);
        chk("midrst_fr_ready", fr_ready_o, 1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_req_ready_after", req_ready_o, 1);
        chk("midrst_fa_valid_after", fa_valid_o, 0);
        chk("scoreboard_drained", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
